// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the "does this instruction write a register" rule.
package pipeline_pkg;

    localparam int FLAGS_W        = 17;
    localparam int REG_ADDR_W     = 5;
    localparam int FLAG_REG_WRITE = 0;
    localparam int FLAG_JALR      = 10;

    function automatic logic is_tracked(input logic                  valid,
                                        input logic                  reg_write,
                                        input logic [REG_ADDR_W-1:0] rd);
        return valid && reg_write && (rd != '0);
    endfunction

endpackage

// File: rtl/scoreboard_counter.sv
// Per-register outstanding-write counter; holds at both ends instead of wrapping.
module scoreboard_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic zero,
    output logic full,
    output logic underflow
);

    localparam logic [CNT_W-1:0] ONE_C = 1;

    logic [CNT_W-1:0] r_count;

    // Concurrent inc and dec cancel, even when the count is zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !dec && !full) begin
            r_count <= r_count + ONE_C;
        end else if (dec && !inc && !zero) begin
            r_count <= r_count - ONE_C;
        end
    end

    assign zero      = (r_count == '0);
    assign full      = (r_count == '1);
    assign underflow = dec && zero && !clr;

endmodule

// File: rtl/pipeline_scoreboard.sv
// Register-write scoreboard: tracks outstanding writes from issue to writeback
// and produces the decode hazard stall.
module pipeline_scoreboard
    import pipeline_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int CNT_W = 2,
    parameter int TOT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [FLAGS_W-1:0]    issue_flags,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    input  logic                  wb_valid,
    input  logic [FLAGS_W-1:0]    wb_flags,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  flush,
    output logic                  rs1_pending,
    output logic                  rs2_pending,
    output logic                  issue_stall,
    output logic [NREGS-1:0]      pending_mask,
    output logic [TOT_W-1:0]      inflight,
    output logic                  underflow_err
);

    localparam logic [TOT_W-1:0] ONE_T = 1;

    logic [NREGS-1:0] w_zero;
    logic [NREGS-1:0] w_full;
    logic [NREGS-1:0] w_underflow;
    logic             w_issue_trk;
    logic             w_wb_trk;
    logic             w_accept;
    logic             w_wb_dec;
    logic             w_unused_flags;

    logic [TOT_W-1:0] r_inflight;
    logic             r_underflow_err;

    assign w_unused_flags = ^{issue_flags[FLAGS_W-1:1], wb_flags[FLAGS_W-1:1]};

    assign w_issue_trk = is_tracked(issue_valid, issue_flags[FLAG_REG_WRITE], issue_rd);
    assign w_wb_trk    = is_tracked(wb_valid, wb_flags[FLAG_REG_WRITE], wb_rd);

    // x0 is hard-wired as never pending and never full.
    assign w_zero[0]      = 1'b1;
    assign w_full[0]      = 1'b0;
    assign w_underflow[0] = 1'b0;

    for (genvar i = 1; i < NREGS; i++) begin : g_cnt
        scoreboard_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (w_accept && (issue_rd == REG_ADDR_W'(i))),
            .dec       (w_wb_trk && (wb_rd == REG_ADDR_W'(i))),
            .clr       (flush),
            .zero      (w_zero[i]),
            .full      (w_full[i]),
            .underflow (w_underflow[i])
        );
    end

    // No writeback bypass: a register retiring this cycle still reads as pending.
    assign rs1_pending = issue_valid && (issue_rs1 != '0) && !w_zero[issue_rs1];
    assign rs2_pending = issue_valid && (issue_rs2 != '0) && !w_zero[issue_rs2];
    assign issue_stall = rs1_pending || rs2_pending || (w_issue_trk && w_full[issue_rd]);

    assign w_accept = w_issue_trk && !issue_stall;
    assign w_wb_dec = w_wb_trk && !w_zero[wb_rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else if (flush) begin
            r_inflight <= '0;
        end else if (w_accept && !w_wb_dec) begin
            if (r_inflight != '1) r_inflight <= r_inflight + ONE_T;
        end else if (w_wb_dec && !w_accept) begin
            if (r_inflight != '0) r_inflight <= r_inflight - ONE_T;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underflow_err <= 1'b0;
        end else if (|w_underflow) begin
            r_underflow_err <= 1'b1;
        end
    end

    assign pending_mask  = ~w_zero;
    assign inflight      = r_inflight;
    assign underflow_err = r_underflow_err;

endmodule
